fcvt_wb_queue: RTL

//  Writeback stage directly downstream of the FP<->int converter. Accepts one conversion

---
 rtl/fcvt_wb_queue.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/fcvt_wb_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fcvt_wb_queue                                                |
// | Description : Writeback queue behind the FP<->int converter. Computes      |
// |               RISC-V fflags (NV/NX) from the source operand at push time,  |
// |               applies the NaN result fix-up, buffers DEPTH entries and     |
// |               accrues the head entry's flags when it retires.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fcvt_wb_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  // converter side
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [31:0]   in_result_i,
  input  logic [31:0]   in_operand_i,
  input  logic          in_conv_type_i,
  input  logic          in_op_signed_i,
  input  logic [4:0]    in_rd_i,
  // register-file side
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [31:0]   out_data_o,
  output logic [4:0]    out_rd_o,
  output logic          out_fp_dest_o,
  output logic [4:0]    out_fflags_o,
  // flag accrual and occupancy
  output logic [4:0]    fflags_acc_o,
  input  logic          fflags_clr_i,
  output logic [CW-1:0] count_o
);

  localparam int            c_ptr_w = $clog2(DEPTH);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  // Float field positions where the rounding point is reached: biased exponent
  // 150 puts the binary point just below m[0]; 158 is the 2^31 boundary.
  localparam logic [7:0]    c_exp_one   = 8'd127;
  localparam logic [7:0]    c_exp_int   = 8'd150;
  localparam logic [7:0]    c_exp_2p31  = 8'd158;
  localparam logic [7:0]    c_exp_max   = 8'hFF;
  localparam logic [4:0]    c_i2f_prec  = 5'd23;

  // ---------------------------------------------------------------------------
  // Storage and control state
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0][31:0] r_data;
  logic [DEPTH-1:0][4:0]  r_rd;
  logic [DEPTH-1:0]       r_fp;
  logic [DEPTH-1:0][4:0]  r_flags;

  logic [c_ptr_w-1:0]     r_wr_ptr;
  logic [c_ptr_w-1:0]     r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [4:0]             r_acc;

  logic                   w_push;
  logic                   w_pop;

  // ---------------------------------------------------------------------------
  // Handshake: ready depends only on occupancy, so a full queue refuses a push
  // even when the head retires in the same cycle.
  // ---------------------------------------------------------------------------
  assign in_ready_o  = (r_count != c_depth);
  assign out_valid_o = (r_count != '0);
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;

  // ---------------------------------------------------------------------------
  // float->int flag evaluation
  // ---------------------------------------------------------------------------
  logic [7:0]  w_exp;
  logic [22:0] w_man;
  logic        w_sgn;
  logic        w_is_nan;
  logic [7:0]  w_frac_sh;
  logic [22:0] w_frac_mask;
  logic        w_f2i_nv;
  logic        w_f2i_nx;

  assign w_exp = in_operand_i[30:23];
  assign w_man = in_operand_i[22:0];
  assign w_sgn = in_operand_i[31];

  // Range check for the target integer, then look for dropped fraction bits.
  always_comb begin
    w_is_nan    = (w_exp == c_exp_max) && (w_man != '0);
    // Number of mantissa bits below the binary point; only meaningful for
    // 127 <= exp < 150, where it spans 23 down to 1.
    w_frac_sh   = c_exp_int - w_exp;
    w_frac_mask = 23'((24'h1 << w_frac_sh) - 24'h1);

    if (in_op_signed_i) begin
      // -2^31 is the single exact value at exponent 158
      w_f2i_nv = (w_exp > c_exp_2p31) ||
                 ((w_exp == c_exp_2p31) && !(w_sgn && (w_man == '0)));
    end else begin
      // any negative value with magnitude >= 1 cannot be represented
      w_f2i_nv = (w_exp > c_exp_2p31) || (w_sgn && (w_exp >= c_exp_one));
    end

    if (w_exp < c_exp_one) begin
      w_f2i_nx = (in_operand_i[30:0] != '0);
    end else if (w_exp < c_exp_int) begin
      w_f2i_nx = ((w_man & w_frac_mask) != '0);
    end else begin
      w_f2i_nx = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // int->float flag evaluation
  // ---------------------------------------------------------------------------
  logic [31:0] w_mag;
  logic [4:0]  w_lead;
  logic [31:0] w_lsb_mask;
  logic        w_i2f_nx;

  // Leading-one search on the magnitude; bits below the 24-bit significand
  // window make the conversion inexact.
  always_comb begin
    w_mag = (in_op_signed_i && in_operand_i[31]) ? (32'd0 - in_operand_i)
                                                 : in_operand_i;
    w_lead = '0;
    for (int i = 0; i < 32; i++) begin
      if (w_mag[i]) begin
        w_lead = 5'(i);
      end
    end
    w_lsb_mask = (32'h1 << (w_lead - c_i2f_prec)) - 32'h1;
    w_i2f_nx   = (w_lead > c_i2f_prec) && ((w_mag & w_lsb_mask) != '0);
  end

  // ---------------------------------------------------------------------------
  // Entry assembly: flags {NV,DZ,OF,UF,NX} and NaN data fix-up
  // ---------------------------------------------------------------------------
  logic [4:0]  w_push_flags;
  logic [31:0] w_push_data;

  // NX is suppressed whenever NV fires; NaN inputs saturate to the largest
  // positive integer of the destination type.
  always_comb begin
    w_push_flags = '0;
    w_push_data  = in_result_i;
    if (in_conv_type_i) begin
      w_push_flags[0] = w_i2f_nx;
    end else begin
      w_push_flags[4] = w_f2i_nv;
      w_push_flags[0] = w_f2i_nx & ~w_f2i_nv;
      if (w_is_nan) begin
        w_push_data = in_op_signed_i ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Entry storage: written at the write pointer on every accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data  <= '0;
      r_rd    <= '0;
      r_fp    <= '0;
      r_flags <= '0;
    end else if (w_push) begin
      r_data[r_wr_ptr]  <= w_push_data;
      r_rd[r_wr_ptr]    <= in_rd_i;
      r_fp[r_wr_ptr]    <= in_conv_type_i;
      r_flags[r_wr_ptr] <= w_push_flags;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks push/pop balance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Accrued flags: a CSR clear applies before the retiring entry's flags merge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
    end else if (w_pop) begin
      r_acc <= (fflags_clr_i ? 5'd0 : r_acc) | out_fflags_o;
    end else if (fflags_clr_i) begin
      r_acc <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: head entry straight from storage
  // ---------------------------------------------------------------------------
  assign out_data_o    = r_data[r_rd_ptr];
  assign out_rd_o      = r_rd[r_rd_ptr];
  assign out_fp_dest_o = r_fp[r_rd_ptr];
  assign out_fflags_o  = r_flags[r_rd_ptr];
  assign fflags_acc_o  = r_acc;
  assign count_o       = r_count;

endmodule
`default_nettype wire
